fuzzy_pi_accumulator: RTL and testbench

FUZZY_PI_ACCUMULATOR -- requirements
Module: fuzzy_pi_accumulator

---
 rtl/fuzzy_pkg.sv | 21 ++
 rtl/fuzzy_pi_accumulator_if.sv | 43 ++++
 rtl/serial_mult_signed.sv | 61 ++++++
 rtl/fuzzy_pi_accumulator.sv | 126 ++++++++++++
 tb/tb_fuzzy_pi_accumulator.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/fuzzy_pkg.sv
// Q-format constants and FSM encoding shared
// by the fuzzy PI datapath blocks.
package fuzzy_pkg;

  localparam int Q_N  = 16;
  localparam int Q_KN = 4;
  localparam int Q_SH = Q_N - Q_KN;

  localparam int S_IDLE = 0;
  localparam int S_MUL  = 1;
  localparam int S_ACC  = 2;
  localparam int S_SAT  = 3;

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    MUL  = 4'b0010,
    ACC  = 4'b0100,
    SAT  = 4'b1000
  } pi_state_t;

endpackage

// File: rtl/fuzzy_pi_accumulator_if.sv
// Increment/result bundle between the fuzzy
// regulator and the PI accumulator.
interface fuzzy_pi_accumulator_if
  import fuzzy_pkg::*;
#(
  parameter int N = Q_N
);

  logic         du_valid;
  logic [N-1:0] du;
  logic [N-1:0] k_gain;
  logic [N-1:0] u_max;
  logic [N-1:0] u_min;
  logic         clear;
  logic [N-1:0] u_init;
  logic         hold;
  logic [N-1:0] u;
  logic         u_valid;
  logic         busy;
  logic         sat_hi;
  logic         sat_lo;
  logic         overrun;
  logic         cfg_err;

  modport master (
    output du_valid, du, k_gain,
    output u_max, u_min,
    output clear, u_init, hold,
    input  u, u_valid, busy,
    input  sat_hi, sat_lo,
    input  overrun, cfg_err
  );

  modport slave (
    input  du_valid, du, k_gain,
    input  u_max, u_min,
    input  clear, u_init, hold,
    output u, u_valid, busy,
    output sat_hi, sat_lo,
    output overrun, cfg_err
  );

endinterface

// File: rtl/serial_mult_signed.sv
// Serial shift-add signed multiplier, one
// multiplier bit per cycle, N cycles per product.
module serial_mult_signed #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] product,
  output logic           rdy,
  output logic           done
);

  localparam int CW = $clog2(N);

  logic [2*N-1:0] mcand;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] addend;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           run;
  logic           last;

  assign last    = (cnt == CW'(N - 1));
  assign done    = run & last;
  assign rdy     = ~run;
  assign product = acc;
  assign addend  = mplier[0] ? mcand : '0;

  // The sign bit of b carries weight -2^(N-1),
  // so the final step subtracts instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (abort) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      mcand  <= {{N{a[N-1]}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      run    <= 1'b1;
    end else if (run) begin
      acc    <= last ? acc - addend
                     : acc + addend;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (last) run <= 1'b0;
    end
  end

endmodule

// File: rtl/fuzzy_pi_accumulator.sv
// Integrating output stage of the fuzzy PI:
// u += (du * k_gain) scaled, then clamped.
module fuzzy_pi_accumulator
  import fuzzy_pkg::*;
#(
  parameter int N  = Q_N,
  parameter int KN = Q_KN
) (
  input logic clk,
  input logic rst,
  fuzzy_pi_accumulator_if.slave bus
);

  localparam int SH = N - KN;
  localparam int W  = N + KN + 1;

  pi_state_t state;
  pi_state_t state_nx;

  logic           accept;
  logic           mult_rdy;
  logic           mult_done;
  logic [2*N-1:0] prod;
  logic [N-1:0]   umax_r;
  logic [N-1:0]   umin_r;

  logic signed [W-1:0] inc;
  logic signed [W-1:0] u_x;
  logic signed [W-1:0] sum_nx;
  logic signed [W-1:0] sum_r;
  logic signed [W-1:0] umax_x;
  logic signed [W-1:0] umin_x;

  assign accept = state[S_IDLE] & mult_rdy
                & bus.du_valid & ~bus.clear;
  assign bus.busy = ~state[S_IDLE];

  assign inc    = W'($signed(prod) >>> SH);
  assign u_x    = W'($signed(bus.u));
  assign umax_x = W'($signed(umax_r));
  assign umin_x = W'($signed(umin_r));
  assign sum_nx = bus.hold ? u_x : u_x + inc;

  serial_mult_signed #(.N(N)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (accept),
    .abort   (bus.clear),
    .a       (bus.du),
    .b       (bus.k_gain),
    .product (prod),
    .rdy     (mult_rdy),
    .done    (mult_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (bus.clear) begin
      state_nx = IDLE;
    end else begin
      unique case (1'b1)
        state[S_IDLE]: if (accept) state_nx = MUL;
        state[S_MUL]:  if (mult_done) state_nx = ACC;
        state[S_ACC]:  state_nx = SAT;
        state[S_SAT]:  state_nx = IDLE;
        default:       state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.u       <= '0;
      bus.u_valid <= 1'b0;
      bus.sat_hi  <= 1'b0;
      bus.sat_lo  <= 1'b0;
      bus.overrun <= 1'b0;
      bus.cfg_err <= 1'b0;
      umax_r      <= '0;
      umin_r      <= '0;
      sum_r       <= '0;
    end else if (bus.clear) begin
      bus.u       <= bus.u_init;
      bus.u_valid <= 1'b0;
      bus.sat_hi  <= 1'b0;
      bus.sat_lo  <= 1'b0;
      bus.overrun <= 1'b0;
      bus.cfg_err <= 1'b0;
    end else begin
      bus.u_valid <= 1'b0;
      if (bus.du_valid && !state[S_IDLE])
        bus.overrun <= 1'b1;
      if (accept) begin
        umax_r <= bus.u_max;
        umin_r <= bus.u_min;
      end
      if (state[S_ACC]) sum_r <= sum_nx;
      // Inverted limits fall back to u_min.
      if (state[S_SAT]) begin
        bus.u_valid <= 1'b1;
        bus.cfg_err <= 1'b0;
        bus.sat_hi  <= 1'b0;
        bus.sat_lo  <= 1'b0;
        if (umin_x > umax_x) begin
          bus.u       <= umin_r;
          bus.sat_lo  <= 1'b1;
          bus.cfg_err <= 1'b1;
        end else if (sum_r > umax_x) begin
          bus.u      <= umax_r;
          bus.sat_hi <= 1'b1;
        end else if (sum_r < umin_x) begin
          bus.u      <= umin_r;
          bus.sat_lo <= 1'b1;
        end else begin
          bus.u <= sum_r[N-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_fuzzy_pi_accumulator.sv
// Scoreboard bench for fuzzy_pi_accumulator
// with an integer reference model.
module tb_fuzzy_pi_accumulator;

  typedef struct {
    logic [15:0] u;
    logic        hi;
    logic        lo;
    logic        ce;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  longint mu;
  exp_t exp_q[$];

  fuzzy_pi_accumulator_if #(.N(16)) bus();

  fuzzy_pi_accumulator #(.N(16), .KN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input longint act,
                       input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, req);
    end
  endtask

  function automatic longint sx(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  // Reference: exact product, floor divide by 2^12,
  // integrate, then clamp.
  function automatic exp_t model(
    input logic [15:0] d, k, mx, mn,
    input logic h);
    exp_t   r;
    longint p, inc, s, res;
    p = sx(d) * sx(k);
    if (p >= 0) inc = p / 4096;
    else        inc = -((-p + 4095) / 4096);
    s = h ? mu : mu + inc;
    r.hi = 0; r.lo = 0; r.ce = 0;
    if (sx(mn) > sx(mx)) begin
      res = sx(mn); r.lo = 1; r.ce = 1;
    end else if (s > sx(mx)) begin
      res = sx(mx); r.hi = 1;
    end else if (s < sx(mn)) begin
      res = sx(mn); r.lo = 1;
    end else begin
      res = s;
    end
    r.u = res[15:0];
    r.cyc = 0;
    mu = res;
    return r;
  endfunction

  always @(negedge clk) begin
    if (bus.u_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_u_valid: got u=%h expected none",
                 bus.u);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("u", bus.u, e.u);
        check("sat_hi", bus.sat_hi, e.hi);
        check("sat_lo", bus.sat_lo, e.lo);
        check("cfg_err", bus.cfg_err, e.ce);
        check("latency", cyc - e.cyc, 19);
      end
    end
  end

  task automatic issue(input logic [15:0] d, k, mx, mn,
                       input logic h, input bit track);
    exp_t e;
    @(posedge clk); #1;
    bus.du = d; bus.k_gain = k;
    bus.u_max = mx; bus.u_min = mn;
    bus.hold = h; bus.du_valid = 1'b1;
    if (track) begin
      e = model(d, k, mx, mn, h);
      e.cyc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.du_valid = 1'b0;
  endtask

  task automatic run(input logic [15:0] d, k, mx, mn,
                     input logic h);
    issue(d, k, mx, mn, h, 1'b1);
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic do_clear(input logic [15:0] ui);
    @(posedge clk); #1;
    bus.clear = 1'b1; bus.u_init = ui;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    mu = sx(ui);
    check("clear_u", bus.u, ui);
  endtask

  initial begin
    logic [15:0] a, b, mx, mn;
    checks = 0; errors = 0; mu = 0;
    rst = 1'b0;
    bus.du_valid = 0; bus.du = 0; bus.k_gain = 0;
    bus.u_max = 0; bus.u_min = 0; bus.clear = 0;
    bus.u_init = 0; bus.hold = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    check("rst_u", bus.u, 0);
    check("rst_u_valid", bus.u_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_sat_hi", bus.sat_hi, 0);
    check("rst_sat_lo", bus.sat_lo, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_cfg_err", bus.cfg_err, 0);

    run(16'h0800, 16'h1000, 16'h7FFF, 16'h8000, 0);
    do_clear(16'h0000);
    run(16'hF800, 16'h2000, 16'h7FFF, 16'h8000, 0);
    do_clear(16'h3C00);
    run(16'h0800, 16'h1000, 16'h4000, 16'h8000, 0);
    do_clear(16'h3C00);
    run(16'h8000, 16'h1000, 16'h7FFF, 16'hC000, 0);
    run(16'h0400, 16'h1000, 16'h1000, 16'h2000, 0);
    run(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000, 1);

    // Second strobe mid-multiply with junk limits.
    issue(16'h0300, 16'h1800, 16'h7FFF, 16'h8000, 0, 1);
    repeat (4) @(posedge clk);
    #1;
    bus.du = 16'h7000; bus.u_max = 16'h0000;
    bus.u_min = 16'h0000; bus.du_valid = 1'b1;
    @(posedge clk); #1;
    bus.du_valid = 1'b0;
    check("overrun_set", bus.overrun, 1);
    repeat (16) @(posedge clk);
    #1;
    check("overrun_sticky", bus.overrun, 1);

    // Reset during multiply.
    issue(16'h1111, 16'h1000, 16'h7FFF, 16'h8000, 0, 0);
    repeat (7) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    mu = 0;
    check("abort_u", bus.u, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_overrun", bus.overrun, 0);
    repeat (22) @(posedge clk);
    #1;
    run(16'h0200, 16'h3000, 16'h7FFF, 16'h8000, 0);

    // Clear wins over a simultaneous strobe.
    @(posedge clk); #1;
    bus.clear = 1'b1; bus.u_init = 16'h1234;
    bus.du = 16'h4000; bus.k_gain = 16'h1000;
    bus.du_valid = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0; bus.du_valid = 1'b0;
    mu = sx(16'h1234);
    check("clr_u", bus.u, 16'h1234);
    check("clr_overrun", bus.overrun, 0);
    check("clr_busy", bus.busy, 0);
    repeat (22) @(posedge clk);
    #1;
    check("clr_idle", bus.busy, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(7) == 0)
        do_clear(16'($urandom));
      a = 16'($urandom);
      b = 16'($urandom);
      if (($urandom_range(7) == 0) ^ ($signed(a) > $signed(b))) begin
        mx = a; mn = b;
      end else begin
        mx = b; mn = a;
      end
      run(16'($urandom), 16'($urandom), mx, mn,
          ($urandom_range(3) == 0));
    end

    repeat (5) @(posedge clk);
    check("pending", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
